// File: rtl/vram_host_arbiter.sv
// rtl/vram_host_arbiter.sv - two-requester VRAM host-port arbiter with optional screen-clear engine
// Define VRAM_CLEAR_EN to build the clear engine and CLEAR state.
module vram_host_arbiter #(
    parameter int ADDR_W    = 13,
    parameter int DATA_W    = 8,
    parameter int CLR_WORDS = 4000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              aReq,
    input  logic              aWr,
    input  logic [ADDR_W-1:0] aAddr,
    input  logic [DATA_W-1:0] aWrData,
    output logic              aAck,
    output logic [DATA_W-1:0] aRdData,
    output logic              aRdValid,
    input  logic              bReq,
    input  logic              bWr,
    input  logic [ADDR_W-1:0] bAddr,
    input  logic [DATA_W-1:0] bWrData,
    output logic              bAck,
    output logic [DATA_W-1:0] bRdData,
    output logic              bRdValid,
    input  logic              clrStart,
    input  logic [DATA_W-1:0] clrChar,
    input  logic [DATA_W-1:0] clrAttr,
    output logic              clrBusy,
    output logic [ADDR_W-1:0] hostAddr,
    output logic [DATA_W-1:0] hostWrData,
    output logic              hostSelect,
    output logic              hostRd,
    input  logic [DATA_W-1:0] hostRdData
);

    logic prio_b;     // 1: B wins the next tie
    logic a_rd_pend;  // VRAM read data for A is on hostRdData this cycle
    logic b_rd_pend;
    logic a_elig;
    logic b_elig;
    logic grant_a;
    logic grant_b;
    logic arb_en;

    // A request whose ack is high this cycle has already been issued.
    assign a_elig  = aReq & ~aAck;
    assign b_elig  = bReq & ~bAck;
    assign grant_a = a_elig & (~b_elig | ~prio_b);
    assign grant_b = b_elig & (~a_elig | prio_b);

`ifdef VRAM_CLEAR_EN
    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(CLR_WORDS - 1);

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_nxt;
    logic [DATA_W-1:0] fill_char;
    logic [DATA_W-1:0] fill_attr;

    assign cnt_nxt = cnt + 1'b1;
    // Requesters may be granted on the edge that retires the last clear write.
    assign arb_en  = (state == IDLE) ? ~clrStart : (cnt == CLR_LAST);
`else
    logic unused_clr;

    assign unused_clr = ^{clrStart, clrChar, clrAttr};
    assign arb_en     = 1'b1;
    assign clrBusy    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hostSelect <= 1'b0;
            hostRd     <= 1'b1;
            hostAddr   <= '0;
            hostWrData <= '0;
            aAck       <= 1'b0;
            bAck       <= 1'b0;
            aRdValid   <= 1'b0;
            bRdValid   <= 1'b0;
            aRdData    <= '0;
            bRdData    <= '0;
            a_rd_pend  <= 1'b0;
            b_rd_pend  <= 1'b0;
            prio_b     <= 1'b0;
`ifdef VRAM_CLEAR_EN
            state      <= IDLE;
            cnt        <= '0;
            fill_char  <= '0;
            fill_attr  <= '0;
            clrBusy    <= 1'b0;
`endif
        end else begin
            aAck       <= 1'b0;
            bAck       <= 1'b0;
            aRdValid   <= 1'b0;
            bRdValid   <= 1'b0;
            hostSelect <= 1'b0;
            hostRd     <= 1'b1;
            a_rd_pend  <= aAck & hostRd;
            b_rd_pend  <= bAck & hostRd;

            if (a_rd_pend) begin
                aRdData  <= hostRdData;
                aRdValid <= 1'b1;
            end
            if (b_rd_pend) begin
                bRdData  <= hostRdData;
                bRdValid <= 1'b1;
            end

            if (arb_en && grant_a) begin
                hostSelect <= 1'b1;
                hostRd     <= ~aWr;
                hostAddr   <= aAddr;
                hostWrData <= aWrData;
                aAck       <= 1'b1;
                prio_b     <= 1'b1;
            end else if (arb_en && grant_b) begin
                hostSelect <= 1'b1;
                hostRd     <= ~bWr;
                hostAddr   <= bAddr;
                hostWrData <= bWrData;
                bAck       <= 1'b1;
                prio_b     <= 1'b0;
            end

`ifdef VRAM_CLEAR_EN
            if (state == IDLE) begin
                if (clrStart) begin
                    fill_char  <= clrChar;
                    fill_attr  <= clrAttr;
                    cnt        <= '0;
                    state      <= CLEAR;
                    clrBusy    <= 1'b1;
                    hostSelect <= 1'b1;
                    hostRd     <= 1'b0;
                    hostAddr   <= '0;
                    hostWrData <= clrChar;
                end
            end else begin
                if (cnt == CLR_LAST) begin
                    state   <= IDLE;
                    clrBusy <= 1'b0;
                end else begin
                    cnt        <= cnt_nxt;
                    hostSelect <= 1'b1;
                    hostRd     <= 1'b0;
                    hostAddr   <= cnt_nxt;
                    hostWrData <= cnt_nxt[0] ? fill_attr : fill_char;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_vram_host_arbiter.sv
// tb/tb_vram_host_arbiter.sv - scoreboard testbench for vram_host_arbiter
module tb_vram_host_arbiter;
    localparam int AW = 13;
    localparam int DW = 8;
    localparam int CW = 4000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          aReq = 1'b0, bReq = 1'b0, aWr = 1'b0, bWr = 1'b0;
    logic [AW-1:0] aAddr = '0, bAddr = '0;
    logic [DW-1:0] aWrData = '0, bWrData = '0;
    logic          aAck, bAck, aRdValid, bRdValid, clrBusy, hostSelect, hostRd;
    logic [DW-1:0] aRdData, bRdData, hostWrData;
    logic [AW-1:0] hostAddr;
    logic          clrStart = 1'b0;
    logic [DW-1:0] clrChar = '0, clrAttr = '0;
    logic [DW-1:0] hostRdData = '0;

    typedef struct {
        logic [1:0]    ack;
        logic          rd;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } txn_t;

    txn_t          hq[$];
    logic [DW-1:0] a_rdq[$];
    logic [DW-1:0] b_rdq[$];
    txn_t          mon_t;
    int checks = 0, errors = 0, cyc = 0;
    int sel_first = -1, sel_last = 0, busy_cyc = 0, busy_last = 0;
    int n, na, nb;

    vram_host_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CLR_WORDS(CW)) dut (
        .clk(clk), .rst(rst),
        .aReq(aReq), .aWr(aWr), .aAddr(aAddr), .aWrData(aWrData),
        .aAck(aAck), .aRdData(aRdData), .aRdValid(aRdValid),
        .bReq(bReq), .bWr(bWr), .bAddr(bAddr), .bWrData(bWrData),
        .bAck(bAck), .bRdData(bRdData), .bRdValid(bRdValid),
        .clrStart(clrStart), .clrChar(clrChar), .clrAttr(clrAttr), .clrBusy(clrBusy),
        .hostAddr(hostAddr), .hostWrData(hostWrData), .hostSelect(hostSelect),
        .hostRd(hostRd), .hostRdData(hostRdData)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] vram_val(input logic [AW-1:0] a);
        logic [DW-1:0] v;
        v = a[7:0] ^ 8'h3C;
        if (a == 13'h0010) v = 8'h5A;
        return v;
    endfunction

    // VRAM model: read data valid the cycle after the read access
    always @(posedge clk) if (hostSelect && hostRd) hostRdData <= vram_val(hostAddr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_h(input logic [1:0] ack, input logic rd, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data);
        txn_t t;
        t.ack = ack; t.rd = rd; t.addr = addr; t.data = data;
        hq.push_back(t);
    endtask

    task automatic push_clear(input int words, input logic [DW-1:0] ch, input logic [DW-1:0] at);
        for (int i = 0; i < words; i++) push_h(2'b00, 1'b0, AW'(i), (i % 2 == 0) ? ch : at);
    endtask

    task automatic req_a(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                         input int lim, output int cnt);
        aReq = 1'b1; aWr = wr; aAddr = addr; aWrData = data; cnt = 0;
        do begin @(negedge clk); cnt++; end while (!aAck && cnt < lim);
        if (!aAck) begin
            checks++; errors++;
            $display("FAIL a_ack_timeout: no ack after %0d cycles, expected ack", cnt);
        end
        aReq = 1'b0;
    endtask

    task automatic req_b(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                         input int lim, output int cnt);
        bReq = 1'b1; bWr = wr; bAddr = addr; bWrData = data; cnt = 0;
        do begin @(negedge clk); cnt++; end while (!bAck && cnt < lim);
        if (!bAck) begin
            checks++; errors++;
            $display("FAIL b_ack_timeout: no ack after %0d cycles, expected ack", cnt);
        end
        bReq = 1'b0;
    endtask

    // Monitor: compares every host access and read return against the scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (clrBusy) begin busy_cyc++; busy_last = cyc; end
            if (hostSelect) begin
                if (sel_first < 0) sel_first = cyc;
                sel_last = cyc;
                checks++;
                if (hq.size() == 0) begin
                    errors++;
                    $display("FAIL host_extra: access addr 0x%0h rd %0d, expected no access", hostAddr, hostRd);
                end else begin
                    mon_t = hq.pop_front();
                    chk("host_rd", hostRd, mon_t.rd);
                    chk("host_addr", hostAddr, mon_t.addr);
                    if (!mon_t.rd) chk("host_wrdata", hostWrData, mon_t.data);
                    chk("ack_id", {aAck, bAck}, mon_t.ack);
                end
            end else if (aAck || bAck) begin
                chk("ack_without_select", {aAck, bAck}, 2'b00);
            end
            if (aRdValid) begin
                checks++;
                if (a_rdq.size() == 0) begin
                    errors++; $display("FAIL a_rdvalid_extra: data 0x%0h, expected none", aRdData);
                end else chk("a_rddata", aRdData, a_rdq.pop_front());
            end
            if (bRdValid) begin
                checks++;
                if (b_rdq.size() == 0) begin
                    errors++; $display("FAIL b_rdvalid_extra: data 0x%0h, expected none", bRdData);
                end else chk("b_rddata", bRdData, b_rdq.pop_front());
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_select", hostSelect, 1'b0);
        chk("rst_hostrd", hostRd, 1'b1);
        chk("rst_addr", hostAddr, 0);
        chk("rst_wrdata", hostWrData, 0);
        chk("rst_acks", {aAck, bAck, aRdValid, bRdValid}, 4'b0000);
        chk("rst_rddata", {aRdData, bRdData}, 16'h0000);
        chk("rst_busy", clrBusy, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // single uncontended A write
        push_h(2'b10, 1'b0, 13'h0123, 8'h41);
        req_a(1'b1, 13'h0123, 8'h41, 10, n);
        chk("a_latency", n, 1);
        @(negedge clk);
        chk("a_no_reissue", hostSelect, 1'b0);

        // B read of preloaded 0x5A at 0x0010
        push_h(2'b01, 1'b1, 13'h0010, 8'h00);
        b_rdq.push_back(8'h5A);
        req_b(1'b0, 13'h0010, 8'h00, 10, n);
        chk("b_latency", n, 1);
        @(negedge clk);
        chk("b_rdvalid_t1", bRdValid, 1'b0);
        @(negedge clk);
        chk("b_rdvalid_t2", bRdValid, 1'b1);
        chk("b_rddata_t2", bRdData, 8'h5A);

        // both requesters continuously: strict A,B alternation, one access per cycle
        for (int i = 0; i < 4; i++) begin
            push_h(2'b10, 1'b0, AW'(32'h200 + i), DW'(32'h60 + i));
            push_h(2'b01, 1'b1, AW'(32'h300 + i), 8'h00);
            b_rdq.push_back(vram_val(AW'(32'h300 + i)));
        end
        sel_first = -1;
        fork
            for (int i = 0; i < 4; i++) req_a(1'b1, AW'(32'h200 + i), DW'(32'h60 + i), 20, na);
            for (int j = 0; j < 4; j++) req_b(1'b0, AW'(32'h300 + j), 8'h00, 20, nb);
        join
        repeat (3) @(negedge clk);
        chk("alt_span", sel_last - sel_first, 7);
        chk("alt_reads_done", b_rdq.size(), 0);

        // asynchronous reset in the middle of an issued access
        aReq = 1'b1; aWr = 1'b1; aAddr = 13'h0155; aWrData = 8'h99;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_select", hostSelect, 1'b0);
        chk("arst_hostrd", hostRd, 1'b1);
        chk("arst_addr", hostAddr, 0);
        chk("arst_wrdata", hostWrData, 0);
        chk("arst_ack", aAck, 1'b0);
        aReq = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

`ifdef VRAM_CLEAR_EN
        // full clear with a request arriving mid-clear
        clrChar = 8'h20; clrAttr = 8'h07; clrStart = 1'b1;
        push_clear(CW, 8'h20, 8'h07);
        busy_cyc = 0;
        @(negedge clk);
        clrStart = 1'b0;
        chk("clr_busy_start", clrBusy, 1'b1);
        repeat (48) @(negedge clk);
        push_h(2'b10, 1'b0, 13'h0AAA, 8'h55);
        req_a(1'b1, 13'h0AAA, 8'h55, 5000, n);
        chk("clr_busy_cycles", busy_cyc, CW);
        chk("clr_busy_at_ack", clrBusy, 1'b0);
        chk("clr_ack_cycle", cyc, busy_last + 1);

        // reset at clear word 100, then restart from address 0
        @(negedge clk);
        clrChar = 8'h30; clrAttr = 8'h1F; clrStart = 1'b1;
        push_clear(101, 8'h30, 8'h1F);
        @(negedge clk);
        clrStart = 1'b0;
        n = 0;
        while (!(hostSelect && hostAddr == 13'd100) && n < 300) begin @(negedge clk); n++; end
        chk("clr_reach_100", n < 300, 1'b1);
        #1 rst = 1'b1;
        #1;
        chk("clr_rst_busy", clrBusy, 1'b0);
        chk("clr_rst_select", hostSelect, 1'b0);
        chk("clr_rst_pending", hq.size(), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        clrStart = 1'b1;
        push_clear(CW, 8'h30, 8'h1F);
        @(negedge clk);
        clrStart = 1'b0;
        n = 0;
        while (clrBusy && n < CW + 100) begin @(negedge clk); n++; end
        chk("clr2_done", clrBusy, 1'b0);
        @(negedge clk);
        chk("clr2_all_written", hq.size(), 0);
`else
        // without the clear engine clrStart must not block requests
        clrStart = 1'b1; clrChar = 8'h20; clrAttr = 8'h07;
        push_h(2'b10, 1'b0, 13'h0777, 8'h3C);
        req_a(1'b1, 13'h0777, 8'h3C, 10, n);
        clrStart = 1'b0;
        chk("noclr_latency", n, 1);
        chk("noclr_busy", clrBusy, 1'b0);
`endif

        repeat (4) @(negedge clk);
        chk("host_queue_empty", hq.size(), 0);
        chk("a_rd_queue_empty", a_rdq.size(), 0);
        chk("b_rd_queue_empty", b_rdq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
